muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV64M multiply/divide unit that runs beside the combinational ULA in the execute stage. It takes the same operand and word-mode conventions as the ULA: dataA/dataB are 64-bit and word=1 selects the RV64 *W variant. It completes in multiple cycles behind a start/ready/done handshake. The execute stage stalls on ready=0 and captures result on done.

Parameters:
N, 64, datapath width; only 64 is supported (word mode uses bits [31:0]).
OPW, 3, width of the op field.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request valid; accepted only when ready=1
kill  input  1  pipeline flush; aborts any operation in flight
word  input  1  1 = *W instruction (MULW/DIVW/DIVUW/REMW/REMUW)
op  input  OPW  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
dataA  input  N  rs1 operand
dataB  input  N  rs2 operand
ready  output  1  unit idle, can accept
done  output  1  one-cycle pulse, result valid
result  output  N  final result, held stable until the next accept

Behaviour:
- States:
  - IDLE: ready=1.
  - CALC: iterate.
  - DONE: done=1, ready=0.
  - DONE always goes to IDLE on the next edge.
- Reset (rst=1 at an edge): state=IDLE, ready=1, done=0, result=0, counter=0, internal registers 0.
- Accept: an edge with start=1 and ready=1 latches op, word, and the operands, and moves to CALC or DONE.
  - start while ready=0 is ignored and is not queued.
- Word mode operand preparation:
  - Signed ops use dataA[31:0]/dataB[31:0] sign-extended; unsigned ops use them zero-extended.
  - The final value is the low 32 bits sign-extended to 64, including DIVUW/REMUW.
- MULH/MULHSU/MULHU with word=1 is not a valid encoding: it takes the fast path with result=0.
- Multiply:
  - Radix-2 shift-add on operand magnitudes; sign fixup at the end.
  - MUL returns low N bits of the 2N product; MULH* return the high N bits.
  - MULHSU treats dataA as signed and dataB as unsigned.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = signA^signB; remainder sign = signA.
  - Quotient truncates toward zero.
- Iteration count: 64 CALC cycles for 64-bit ops, 32 for word ops. The last CALC cycle transitions to DONE.
  - done is high in the cycle after the (N+1)th edge following accept (33rd edge for word).
  - ready returns 1 one cycle after done.
- Fast path (accept goes directly to DONE, so done comes one edge after accept):
  - Divide by zero: DIV/DIVU quotient = all ones (after word sign-extension); REM/REMU = dividend (word: sign-extended low 32).
  - Signed overflow: most-negative / -1, i.e. 64-bit 0x8000_0000_0000_0000, or in word mode 0x8000_0000. Result is quotient = dividend, remainder = 0.
  - Invalid word MULH* as above.
- kill:
  - In CALC or DONE: state goes to IDLE on the next edge; done is forced 0 in that cycle; result is not updated.
  - In IDLE with start=1: no accept.
  - kill has priority over start.
- rst has priority over kill and start, and is fully effective mid-operation.
- result updates only on the edge entering DONE.

Decomposition:
- Shared package muldiv_pkg: op enum muldiv_op_t (8 encodings), state enum md_state_t {IDLE, CALC, DONE}, constants ITER64=64 and ITER32=32.
- One sub-module, muldiv_prep: combinational operand and sign conditioning (extend, magnitude, sign flags, special-case detect).
- Top-level muldiv_seq holds the FSM, counter, and shift registers.

Test Plan:
- MUL, word=0, A=7, B=0xFFFF_FFFF_FFFF_FFFD (-3): result=0xFFFF_FFFF_FFFF_FFEB, done exactly 65 edges after accept, ready=0 until the edge after done.
- MULHU, A=0xFFFF_FFFF_FFFF_FFFF, B=2: result=1. MULH with the same operands: result=0xFFFF_FFFF_FFFF_FFFF.
- DIV, A=-20, B=3: result=0xFFFF_FFFF_FFFF_FFFA (-6). REM with the same operands: result=0xFFFF_FFFF_FFFF_FFFE (-2).
- Special cases:
  - DIVU, A=5, B=0: result=0xFFFF_FFFF_FFFF_FFFF, done 1 edge after accept.
  - REMU, A=5, B=0: result=5.
  - DIV, word=1, A=0x8000_0000, B=0xFFFF_FFFF: result=0xFFFF_FFFF_8000_0000.
  - REM, word=1, same operands: result=0.
- MUL, word=1, A=0x4000_0000, B=2: result=0xFFFF_FFFF_8000_0000, done 33 edges after accept.
  - start pulses during CALC are ignored; result does not change before done.
- Abort: kill asserted 10 edges into a 64-bit DIV → no done, ready=1 the next cycle, result keeps its prior value. Repeat the run with rst instead of kill → all outputs at reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_t;

    localparam int ITER64 = 64;
    localparam int ITER32 = 32;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_prep.sv
// Combinational operand conditioning: word-mode extension, magnitudes, sign
// flags and detection of the cases that bypass iteration.
module muldiv_prep
    import muldiv_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         word,
    input  muldiv_op_t   op,
    input  logic [N-1:0] dataA,
    input  logic [N-1:0] dataB,
    output logic [N-1:0] mag_a,
    output logic [N-1:0] mag_b,
    output logic         neg_a,
    output logic         neg_b,
    output logic         fast,
    output logic [N-1:0] fast_res
);

    logic         w_sgn_a, w_sgn_b, w_is_div, w_is_rem;
    logic         w_div_zero, w_ovf, w_bad_w;
    logic [N-1:0] w_ext_a, w_ext_b, w_res_a, w_min;

    always_comb begin
        w_sgn_a  = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        w_sgn_b  = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        w_is_div = op[2];
        w_is_rem = op[2] & op[1];

        w_ext_a = word ? (w_sgn_a ? sext32(dataA[31:0]) : {32'b0, dataA[31:0]}) : dataA;
        w_ext_b = word ? (w_sgn_b ? sext32(dataB[31:0]) : {32'b0, dataB[31:0]}) : dataB;

        neg_a = w_sgn_a & w_ext_a[N-1];
        neg_b = w_sgn_b & w_ext_b[N-1];
        mag_a = neg_a ? -w_ext_a : w_ext_a;
        mag_b = neg_b ? -w_ext_b : w_ext_b;

        // Most-negative value as it appears after word-mode sign extension.
        w_min      = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        w_div_zero = w_is_div & (w_ext_b == '0);
        w_ovf      = w_is_div & w_sgn_a & (w_ext_a == w_min) & (w_ext_b == '1);
        w_bad_w    = word & ~op[2] & (op[1:0] != 2'b00);
        w_res_a    = word ? sext32(dataA[31:0]) : dataA;

        fast     = w_bad_w | w_div_zero | w_ovf;
        fast_res = '0;
        if (w_bad_w)
            fast_res = '0;
        else if (w_div_zero)
            fast_res = w_is_rem ? w_res_a : '1;
        else if (w_ovf)
            fast_res = w_is_rem ? '0 : w_res_a;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, behind a start/ready/done handshake.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N   = 64,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           kill,
    input  logic           word,
    input  logic [OPW-1:0] op,
    input  logic [N-1:0]   dataA,
    input  logic [N-1:0]   dataB,
    output logic           ready,
    output logic           done,
    output logic [N-1:0]   result
);

    md_state_t    r_state;
    muldiv_op_t   r_op;
    logic         r_word, r_neg_p, r_neg_r, r_ready, r_done;
    logic [5:0]   r_cnt;
    logic [N-1:0] r_hi, r_lo, r_b, r_result;

    muldiv_op_t   w_op;
    logic [N-1:0] w_mag_a, w_mag_b, w_fast_res;
    logic         w_neg_a, w_neg_b, w_fast;

    assign w_op = muldiv_op_t'(op);

    muldiv_prep #(.N(N)) u_prep (
        .word     (word),
        .op       (w_op),
        .dataA    (dataA),
        .dataB    (dataB),
        .mag_a    (w_mag_a),
        .mag_b    (w_mag_b),
        .neg_a    (w_neg_a),
        .neg_b    (w_neg_b),
        .fast     (w_fast),
        .fast_res (w_fast_res)
    );

    // One iteration step; r_hi/r_lo hold product or remainder/quotient.
    logic [N:0]     w_msum;
    logic [N-1:0]   w_diff, w_hi_n, w_lo_n, w_q_s, w_r_s;
    logic           w_dok;
    logic [2*N-1:0] w_prod_s;
    logic [31:0]    w_mulw;
    logic [N-1:0]   w_final;

    always_comb begin
        w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_dok  = {r_hi, r_lo[N-1]} >= {1'b0, r_b};
        w_diff = {r_hi[N-2:0], r_lo[N-1]} - r_b;
        if (r_op[2]) begin
            w_hi_n = w_dok ? w_diff : {r_hi[N-2:0], r_lo[N-1]};
            w_lo_n = {r_lo[N-2:0], w_dok};
        end else begin
            w_hi_n = w_msum[N:1];
            w_lo_n = {w_msum[0], r_lo[N-1:1]};
        end

        // After 32 word-mode steps the low product word sits in w_lo_n[63:32].
        w_prod_s = r_neg_p ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
        w_mulw   = r_neg_p ? -w_lo_n[63:32] : w_lo_n[63:32];
        w_q_s    = r_neg_p ? -w_lo_n : w_lo_n;
        w_r_s    = r_neg_r ? -w_hi_n : w_hi_n;

        case (r_op)
            OP_MUL:          w_final = r_word ? sext32(w_mulw) : w_prod_s[N-1:0];
            OP_DIV, OP_DIVU: w_final = r_word ? sext32(w_q_s[31:0]) : w_q_s;
            OP_REM, OP_REMU: w_final = r_word ? sext32(w_r_s[31:0]) : w_r_s;
            default:         w_final = w_prod_s[2*N-1:N];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_word   <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !kill) begin
                        r_op    <= w_op;
                        r_word  <= word;
                        r_neg_p <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_ready <= 1'b0;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_cnt   <= word ? 6'(ITER32 - 1) : 6'(ITER64 - 1);
                            r_hi    <= '0;
                            r_lo    <= w_op[2] ? (word ? {w_mag_a[31:0], 32'b0} : w_mag_a) : w_mag_b;
                            r_b     <= w_op[2] ? w_mag_b : w_mag_a;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_hi  <= w_hi_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt - 6'd1;
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A flush arriving while done is up suppresses the pulse in that same cycle.
    assign done   = r_done & ~kill;
    assign ready  = r_ready;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table with a result scoreboard,
// plus hand sequences for ignored starts, kill and mid-operation reset.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, kill, word;
    logic [2:0]  op;
    logic [63:0] dataA, dataB;
    logic        ready, done;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          edges;
    } vec_t;

    vec_t vecs[24];

    muldiv_seq #(.N(64), .OPW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .word(word), .op(op),
        .dataA(dataA), .dataB(dataB), .ready(ready), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] o, input logic w,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] e, input int ed);
        vec_t v;
        v.name = n; v.op = o; v.word = w; v.a = a; v.b = b; v.exp = e; v.edges = ed;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit noise);
        int n;
        bit got;
        logic [63:0] prev, e;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({v.name, "_ready_pre"}, 64'(ready), 64'd1);
        @(negedge clk);
        op = v.op; word = v.word; dataA = v.a; dataB = v.b; start = 1'b1;
        exp_q.push_back(v.exp);
        prev = result;
        n = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk); #1; n++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                check({v.name, "_busy"}, 64'(ready), 64'd0);
                check({v.name, "_hold"}, result, prev);
                if (noise) begin
                    start = 1'b1; op = 3'($urandom); word = 1'($urandom);
                    dataA = {$urandom, $urandom}; dataB = {$urandom, $urandom};
                end
            end
        end
        start = 1'b0;
        check({v.name, "_got_done"}, 64'(got), 64'd1);
        check({v.name, "_latency"}, 64'(n), 64'(v.edges));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check({v.name, "_result"}, result, e);
        check({v.name, "_ready_in_done"}, 64'(ready), 64'd0);
        $display("txn %s op=%0d word=%0d a=%h b=%h result=%h edges=%0d",
                 v.name, v.op, v.word, v.a, v.b, result, n);
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, 64'(done), 64'd0);
        check({v.name, "_ready_post"}, 64'(ready), 64'd1);
    endtask

    // Start a 64-bit DIV, then abort it 10 edges in with kill or rst.
    task automatic abort_run(input bit use_rst);
        logic [63:0] prev;
        int seen;
        prev = result;
        @(negedge clk);
        op = OP_DIV; word = 1'b0; dataA = 64'hFFFF_FFFF_FFFF_FFEC; dataB = 64'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (use_rst) rst = 1'b1; else kill = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; kill = 1'b0;
        check(use_rst ? "rst_done" : "kill_done", 64'(done), 64'd0);
        check(use_rst ? "rst_ready" : "kill_ready", 64'(ready), 64'd1);
        check(use_rst ? "rst_result" : "kill_result", result, use_rst ? 64'd0 : prev);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check(use_rst ? "rst_no_done" : "kill_no_done", 64'(seen), 64'd0);
        $display("txn %s abort result=%h", use_rst ? "rst" : "kill", result);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; word = 1'b0; op = '0; dataA = '0; dataB = '0;

        vecs[0]  = mk("mul_neg",    OP_MUL,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        vecs[1]  = mk("mulhu",      OP_MULHU,  0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
        vecs[2]  = mk("mulh",       OP_MULH,   0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        vecs[3]  = mk("mulhsu",     OP_MULHSU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        vecs[4]  = mk("div",        OP_DIV,    0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        vecs[5]  = mk("rem",        OP_REM,    0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        vecs[6]  = mk("divu",       OP_DIVU,   0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        vecs[7]  = mk("remu",       OP_REMU,   0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65);
        vecs[8]  = mk("div_negb",   OP_DIV,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        vecs[9]  = mk("rem_negb",   OP_REM,    0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
        vecs[10] = mk("divu_z",     OP_DIVU,   0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        vecs[11] = mk("remu_z",     OP_REMU,   0, 64'd5, 64'd0, 64'd5, 1);
        vecs[12] = mk("div_ovf",    OP_DIV,    0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        vecs[13] = mk("divw_ovf",   OP_DIV,    1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        vecs[14] = mk("remw_ovf",   OP_REM,    1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
        vecs[15] = mk("div_z",      OP_DIV,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        vecs[16] = mk("rem_z",      OP_REM,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1);
        vecs[17] = mk("mulhuw_inv", OP_MULHU,  1, 64'd5, 64'd3, 64'd0, 1);
        vecs[18] = mk("divw",       OP_DIV,    1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 33);
        vecs[19] = mk("remw",       OP_REM,    1, 64'h1234_5678_FFFF_FFEC, 64'hABCD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        vecs[20] = mk("divuw",      OP_DIVU,   1, 64'hFFFF_FFF0, 64'd2, 64'h0000_0000_7FFF_FFF8, 33);
        vecs[21] = mk("remuw",      OP_REMU,   1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'hF, 33);
        vecs[22] = mk("divuw_sx",   OP_DIVU,   1, 64'hFFFF_FFF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 33);
        vecs[23] = mk("mulw",       OP_MUL,    1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);

        for (int i = 0; i < 23; i++) run_vec(vecs[i], 1'b0);
        run_vec(vecs[23], 1'b1);

        // kill outranks start while idle: nothing is accepted.
        @(negedge clk);
        op = OP_DIV; word = 1'b0; dataA = 64'd9; dataB = 64'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_idle_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        check("kill_idle_done", 64'(done), 64'd0);

        abort_run(1'b0);
        abort_run(1'b1);
        run_vec(vecs[0], 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
